// File: rtl/ram_req_ctrl_if.sv
// Request/response handshake and RAM pin bundle for ram_req_ctrl.
// The slave modport is the controller's view; the master modport is the requester/RAM side.
interface ram_req_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  ram_cs;
  logic                  ram_we;
  logic                  ram_oe;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic [DATA_WIDTH-1:0] ram_data_out;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output ram_cs, ram_we, ram_oe, ram_addr, ram_data_in
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  ram_cs, ram_we, ram_oe, ram_addr, ram_data_in
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// Single-outstanding request front-end for the single-port RAM (cs/we/oe + registered read).
// Optional out-of-range error responses are enabled by defining RAM_CTRL_ERR_EN.
package ram_pkg;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 256;
endpackage

module ram_req_ctrl #(
  parameter int unsigned ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = ram_pkg::DEPTH
) (
  input logic          clk,
  input logic          rst,
  ram_req_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    RSP  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  ram_cs_q, ram_cs_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_oe_q, ram_oe_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_in_q, ram_data_in_d;

`ifdef RAM_CTRL_ERR_EN
  logic in_range_c;
  assign in_range_c = (32'(bus.req_addr) < 32'(DEPTH));
`else
  logic unused_depth_c;
  assign unused_depth_c = (DEPTH != 32'd0);
`endif

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      ram_cs_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_oe_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      ram_cs_q      <= ram_cs_d;
      ram_we_q      <= ram_we_d;
      ram_oe_q      <= ram_oe_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_in_q <= ram_data_in_d;
    end
  end

  // Next state; pin values are decoded from the next state so they flop alongside it
  always_comb begin
    state_d       = state_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    ram_addr_d    = ram_addr_q;
    ram_data_in_d = ram_data_in_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          ram_addr_d    = bus.req_addr;
          ram_data_in_d = bus.req_wdata;
          rsp_err_d     = 1'b0;
          state_d       = bus.req_we ? WR : RD;
`ifdef RAM_CTRL_ERR_EN
          if (!in_range_c) begin
            state_d     = RSP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
`endif
        end
      end
      WR:  state_d = IDLE;
      RD:  state_d = CAP;
      CAP: begin
        rsp_rdata_d = bus.ram_data_out;
        state_d     = RSP;
      end
      RSP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
    ram_cs_d    = (state_d == WR) || (state_d == RD) || (state_d == CAP);
    ram_we_d    = (state_d == WR);
    ram_oe_d    = (state_d == CAP);
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.ram_cs      = ram_cs_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_oe      = ram_oe_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_data_in = ram_data_in_q;

endmodule
